// File: rtl/reg_boot_loader_pkg.sv
// rtl/reg_boot_loader_pkg.sv - shared state encoding, header fields and register indices for reg_boot_loader
package reg_boot_loader_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_WAIT_SUM  = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        WAIT_DATA = ST_WAIT_DATA,
        WRITE     = ST_WRITE,
        WAIT_SUM  = ST_WAIT_SUM,
        DONE      = ST_DONE,
        ERROR     = ST_ERROR
    } state_t;

    localparam int MAGIC_HI = 15;
    localparam int MAGIC_LO = 8;
    localparam int LAST_BIT = 7;
    localparam int IDX_HI   = 2;
    localparam int IDX_LO   = 0;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam logic [2:0] REG0 = 3'd0;
    localparam logic [2:0] REG1 = 3'd1;
    localparam logic [2:0] REG2 = 3'd2;
    localparam logic [2:0] REG3 = 3'd3;
    localparam logic [2:0] REG4 = 3'd4;
    localparam logic [2:0] REG5 = 3'd5;
    localparam logic [2:0] SP   = 3'd6;
    localparam logic [2:0] IP   = 3'd7;

endpackage

// File: rtl/reg_boot_loader_onehot.sv
// rtl/reg_boot_loader_onehot.sv - combinational 3-to-8 decoder from register index to regChoose value
module reg_boot_onehot #(
    parameter int unsigned REGS_CODING = 8
) (
    input  logic [2:0]             idx,
    output logic [REGS_CODING-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/reg_boot_loader.sv
// rtl/reg_boot_loader.sv - host word stream to regData/regChoose register loader; optional checksum via REG_BOOT_LOADER_CHECKSUM_EN
module reg_boot_loader
    import reg_boot_loader_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned REGS_CODING = 8,
    parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic [WIDTH-1:0]       inData,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic                   errClear,
    output logic [WIDTH-1:0]       regData,
    output logic [REGS_CODING-1:0] regChoose,
    output logic                   coreRun,
    output logic                   errFlag,
    output logic [3:0]             loadCount
);

    state_t                 state;
    state_t                 next_state;
    logic [2:0]             idx_q;
    logic                   last_q;
    logic [REGS_CODING-1:0] choose_val;
    logic                   take;
    logic                   magic_ok;

    assign take     = inValid && inReady;
    assign magic_ok = (inData[MAGIC_HI:MAGIC_LO] == MAGIC);

    reg_boot_onehot #(
        .REGS_CODING(REGS_CODING)
    ) u_onehot (
        .idx   (idx_q),
        .onehot(choose_val)
    );

`ifdef REG_BOOT_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;

    // Running XOR over header and data words; the checksum word itself is excluded.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sum_q <= '0;
        end else if (state == ERROR && errClear) begin
            sum_q <= '0;
        end else if (take && (state == IDLE || state == WAIT_DATA)) begin
            sum_q <= sum_q ^ inData;
        end
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (take) begin
                    next_state = magic_ok ? WAIT_DATA : ERROR;
                end
            end
            WAIT_DATA: begin
                if (take) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
`ifdef REG_BOOT_LOADER_CHECKSUM_EN
                next_state = last_q ? WAIT_SUM : IDLE;
`else
                next_state = last_q ? DONE : IDLE;
`endif
            end
`ifdef REG_BOOT_LOADER_CHECKSUM_EN
            WAIT_SUM: begin
                if (take) begin
                    next_state = (inData == sum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                next_state = DONE;
            end
            ERROR: begin
                if (errClear) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from next_state so they are registered yet line up with state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            inReady   <= 1'b0;
            coreRun   <= 1'b0;
            errFlag   <= 1'b0;
            idx_q     <= REG0;
            last_q    <= 1'b0;
            regData   <= '0;
            regChoose <= '0;
            loadCount <= 4'd0;
        end else begin
            state   <= next_state;
            inReady <= (next_state == IDLE) || (next_state == WAIT_DATA) ||
                       (next_state == WAIT_SUM);
            coreRun <= (next_state == DONE);
            errFlag <= (next_state == ERROR);
            if (state == IDLE && take) begin
                idx_q  <= inData[IDX_HI:IDX_LO];
                last_q <= inData[LAST_BIT];
            end
            if (state == WAIT_DATA && take) begin
                regData   <= inData;
                regChoose <= choose_val;
            end
            if (state == WRITE) begin
                regChoose <= '0;
                if (loadCount != 4'd15) begin
                    loadCount <= loadCount + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_boot_loader.sv
// tb/tb_reg_boot_loader.sv - randomized self-checking bench for reg_boot_loader against a pair-level model
module tb_reg_boot_loader;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [15:0] inData = 16'h0;
    logic        inValid = 1'b0;
    logic        errClear = 1'b0;
    logic        inReady;
    logic [15:0] regData;
    logic [7:0]  regChoose;
    logic        coreRun;
    logic        errFlag;
    logic [3:0]  loadCount;

    int total = 0;
    int bad = 0;

    reg_boot_loader dut (
        .clock    (clock),
        .resetN   (resetN),
        .inData   (inData),
        .inValid  (inValid),
        .inReady  (inReady),
        .errClear (errClear),
        .regData  (regData),
        .regChoose(regChoose),
        .coreRun  (coreRun),
        .errFlag  (errFlag),
        .loadCount(loadCount)
    );

    always #5 clock = ~clock;

    // Pair-level model: what has been received so far, not how the FSM encodes it.
    bit          m_fresh, m_have_hdr, m_pulse, m_done, m_err, m_sum_wait, m_last, m_took;
    logic [2:0]  m_idx;
    logic [15:0] m_data, m_xor;
    int          m_cnt;
    bit          started = 0;

    function automatic bit m_ready();
        return !m_fresh && !m_pulse && !m_done && !m_err;
    endfunction

    task automatic model_reset();
        m_fresh = 1; m_have_hdr = 0; m_pulse = 0; m_done = 0; m_err = 0;
        m_sum_wait = 0; m_last = 0; m_idx = 0; m_data = 0; m_xor = 0; m_cnt = 0; m_took = 0;
    endtask

    task automatic model_step();
        bit take;
        m_took = 0;
        if (!resetN) return;
        take = inValid && m_ready();
        m_fresh = 0;
        if (m_pulse) begin
            m_pulse = 0;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
`ifdef REG_BOOT_LOADER_CHECKSUM_EN
            if (m_last) m_sum_wait = 1;
`else
            if (m_last) m_done = 1;
`endif
        end else if (m_err) begin
            if (errClear) begin
                m_err = 0; m_xor = 0; m_have_hdr = 0;
            end
        end else if (take) begin
            m_took = 1;
            if (m_sum_wait) begin
                m_sum_wait = 0;
                if (inData == m_xor) m_done = 1;
                else m_err = 1;
            end else if (!m_have_hdr) begin
                m_xor = m_xor ^ inData;
                if (inData[15:8] == 8'hA5) begin
                    m_have_hdr = 1; m_idx = inData[2:0]; m_last = inData[7];
                end else begin
                    m_err = 1;
                end
            end else begin
                m_xor = m_xor ^ inData;
                m_data = inData; m_pulse = 1; m_have_hdr = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            chk("inReady", 32'(inReady), 32'(m_ready()));
            chk("regChoose", 32'(regChoose), m_pulse ? (32'd1 << m_idx) : 32'd0);
            chk("regData", 32'(regData), 32'(m_data));
            chk("coreRun", 32'(coreRun), 32'(m_done));
            chk("errFlag", 32'(errFlag), 32'(m_err));
            chk("loadCount", 32'(loadCount), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        resetN = 0; inValid = 0; errClear = 0;
        model_reset();
        tick();
        resetN = 1;
        tick();
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        inValid = 1; inData = w;
        do begin
            tick();
            n++;
        end while (!m_took && n < 50);
        if (!m_took) chk("send_timeout", 32'(n), 32'd0);
        inValid = 0;
    endtask

    initial begin
        model_reset();
        started = 1;
        #2;
        chk("reset_ready", 32'(inReady), 32'd0);
        chk("reset_choose", 32'(regChoose), 32'd0);
        do_reset();

        // Single pair to reg2.
        send(16'hA502);
        send(16'h1234);
        chk("t1_choose", 32'(regChoose), 32'h04);
        chk("t1_data", 32'(regData), 32'h1234);
        tick();
        chk("t1_choose_off", 32'(regChoose), 32'h0);
        chk("t1_count", 32'(loadCount), 32'd1);
        chk("t1_ready", 32'(inReady), 32'd1);

        // Three pairs, last to ip.
        do_reset();
        send(16'hA500); send(16'h0011);
        chk("t2_p0", 32'(regChoose), 32'h01);
        send(16'hA501); send(16'h0022);
        chk("t2_p1", 32'(regChoose), 32'h02);
        send(16'hA587); send(16'h0040);
        chk("t2_p2", 32'(regChoose), 32'h80);
        tick();
`ifdef REG_BOOT_LOADER_CHECKSUM_EN
        send(16'hA5F5);
`endif
        chk("t2_run", 32'(coreRun), 32'd1);
        inValid = 1; inData = 16'hA501;
        repeat (3) tick();
        chk("t2_stall", 32'(inReady), 32'd0);
        inValid = 0;

        // Bad magic, then recovery.
        do_reset();
        send(16'h5A00);
        chk("t3_err", 32'(errFlag), 32'd1);
        chk("t3_ready", 32'(inReady), 32'd0);
        errClear = 1; tick(); errClear = 0;
        chk("t3_clear", 32'(errFlag), 32'd0);
        send(16'hA503); send(16'h0ABC);
        chk("t3_write", 32'(regChoose), 32'h08);
        tick();

        // Async reset during WRITE to reg3.
        do_reset();
        send(16'hA503); send(16'h0777);
        chk("t4_pre", 32'(regChoose), 32'h08);
        #2;
        resetN = 0;
        model_reset();
        #1;
        chk("t4_async_choose", 32'(regChoose), 32'h0);
        chk("t4_async_data", 32'(regData), 32'h0);
        tick();
        resetN = 1;
        tick();
        send(16'hA505); send(16'h0505);
        chk("t4_after", 32'(regChoose), 32'h20);
        tick();

        // Back-pressure between header and data.
        send(16'hA504);
        repeat (5) begin
            tick();
            chk("t5_hold", 32'(regChoose), 32'h0);
        end
        send(16'h0555);
        chk("t5_write", 32'(regChoose), 32'h10);
        tick();

`ifdef REG_BOOT_LOADER_CHECKSUM_EN
        do_reset();
        send(16'hA586); send(16'h0100); tick();
        send(16'hA486);
        chk("cs_good", 32'(coreRun), 32'd1);
        do_reset();
        send(16'hA586); send(16'h0100); tick();
        send(16'hA487);
        chk("cs_bad_err", 32'(errFlag), 32'd1);
        chk("cs_bad_run", 32'(coreRun), 32'd0);
`endif

        // Randomized traffic checked by the per-cycle compare process.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            int r = $urandom_range(0, 99);
            inValid = ($urandom_range(0, 3) != 0);
            errClear = ($urandom_range(0, 5) == 0);
            if (m_sum_wait && $urandom_range(0, 1) == 1) inData = m_xor;
            else if (r < 85) inData = {8'hA5, ($urandom_range(0, 9) == 0), 4'($urandom), 3'($urandom)};
            else inData = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                resetN = 0;
                model_reset();
                tick();
                resetN = 1;
            end else if ((m_done || m_err) && $urandom_range(0, 29) == 0 && !errClear) begin
                resetN = 0;
                model_reset();
                tick();
                resetN = 1;
            end
            tick();
        end
        inValid = 0; errClear = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
